// File: rtl/uart_rx_if.sv
// Serial receive interface: the raw line into the receiver and the decoded byte/status out of it.
interface uart_rx_if;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        output rxd,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );

    modport slave (
        input  rxd,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling from a phase accumulator, 2-of-3 majority vote per bit,
// one-cycle rx_valid / rx_frame_err pulses.
module uart_rx #(
    parameter int unsigned CLK_FREQUENCY = 24_000_000,
    parameter int unsigned BAUD          = 9600,
    parameter int unsigned ACC_WIDTH     = 17
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave rx_if
);

    localparam longint unsigned OsIncWide =
        ((longint'(BAUD) * 64'd16) << ACC_WIDTH) / longint'(CLK_FREQUENCY);
    localparam logic [ACC_WIDTH:0] OS_INC = (ACC_WIDTH + 1)'(OsIncWide);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e             state_q, state_d;
    logic               rxd_m_q, rxd_s_q, rxd_p_q;
    logic [ACC_WIDTH:0] acc_q, acc_d;
    logic               os_tick_q, os_tick_d;
    logic [3:0]         os_cnt_q, os_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [1:0]         samp_q, samp_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;

    logic start_edge, decide, wrap, maj;

    assign start_edge = (state_q == StIdle) && rxd_p_q && !rxd_s_q;
    assign decide     = os_tick_q && (os_cnt_q == 4'd9);
    assign wrap       = os_tick_q && (os_cnt_q == 4'd15);
    // samp_q holds the os_cnt=7/8 samples; the os_cnt=9 sample is the live value
    assign maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s_q) | (samp_q[1] & rxd_s_q);

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rxd_m_q   <= 1'b1;
            rxd_s_q   <= 1'b1;
            rxd_p_q   <= 1'b1;
            acc_q     <= '0;
            os_tick_q <= 1'b0;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            samp_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rxd_m_q   <= rx_if.rxd;
            rxd_s_q   <= rxd_m_q;
            rxd_p_q   <= rxd_s_q;
            acc_q     <= acc_d;
            os_tick_q <= os_tick_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            samp_q    <= samp_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_edge) state_d = StStart;
            StStart: begin
                if (decide && maj) begin
                    state_d = StIdle;
                end else if (wrap) begin
                    state_d = StData;
                end
            end
            StData:  if (wrap && (bit_cnt_q == 3'd7)) state_d = StStop;
            // Leave before the wrap so a back-to-back start edge is not missed
            StStop:  if (decide) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        acc_d     = {1'b0, acc_q[ACC_WIDTH-1:0]} + OS_INC;
        os_tick_d = acc_q[ACC_WIDTH];
        os_cnt_d  = os_tick_q ? os_cnt_q + 4'd1 : os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        samp_d    = samp_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        if (os_tick_q && (os_cnt_q == 4'd7)) samp_d[0] = rxd_s_q;
        if (os_tick_q && (os_cnt_q == 4'd8)) samp_d[1] = rxd_s_q;

        // Re-phase the oversample grid to the start edge
        if (start_edge) begin
            acc_d     = '0;
            os_tick_d = 1'b0;
            os_cnt_d  = '0;
            bit_cnt_d = '0;
        end

        if (state_q == StData) begin
            if (decide) shreg_d = {maj, shreg_q[7:1]};
            if (wrap && (bit_cnt_q != 3'd7)) bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if ((state_q == StStop) && decide) begin
            valid_d = maj;
            ferr_d  = !maj;
            if (maj) data_d = shreg_q;
        end
    end

    // Outputs
    always_comb begin
        rx_if.rx_data      = data_q;
        rx_if.rx_valid     = valid_q;
        rx_if.rx_frame_err = ferr_q;
        rx_if.rx_busy      = (state_q != StIdle);
    end

endmodule
